piradip_axis_sample_deinterleaver: RTL

AXI4-Stream sample de-interleaver that splits one packed IQ stream into separate I and Q streams. It sits on the DAC/transmit path between the DMA/IQ source and per-channel sample consumers. It reverses the packing applied by the team's sample interleaver on the capture path. Dual-channel beats are split sample-by-sample. Single-channel beats are unpacked into two consecutive half-width output beats.

---
 rtl/piradip_axis_sample_deinterleaver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/piradip_axis_sample_deinterleaver.sv
// Splits a packed IQ AXI4-Stream into separate I and Q streams (dual: sample split, single: two half beats).
// Optional tlast pass-through is enabled by defining PIRADIP_DEINTERLEAVE_TLAST_EN.
module piradip_axis_sample_deinterleaver #(
  parameter  int SAMPLE_WIDTH = 16,
  parameter  int N_SAMPLES    = 4,
  localparam int OW           = N_SAMPLES * SAMPLE_WIDTH,
  localparam int IW           = 2 * OW,
  localparam int BW           = OW / 8
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          i_en,
  input  logic          q_en,
  input  logic [IW-1:0] s_iq_tdata,
`ifdef PIRADIP_DEINTERLEAVE_TLAST_EN
  input  logic          s_iq_tlast,
  output logic          m_i_tlast,
  output logic          m_q_tlast,
`endif
  input  logic          s_iq_tvalid,
  output logic          s_iq_tready,
  output logic [OW-1:0] m_i_tdata,
  output logic [BW-1:0] m_i_tstrb,
  output logic          m_i_tvalid,
  input  logic          m_i_tready,
  output logic [OW-1:0] m_q_tdata,
  output logic [BW-1:0] m_q_tstrb,
  output logic          m_q_tvalid,
  input  logic          m_q_tready
);

  typedef enum logic {PH0 = 1'b0, PH1 = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d, mode_cur;
  logic [OW-1:0] hold_q, hold_d;
  logic [OW-1:0] i_data_q, i_data_d, q_data_q, q_data_d;
  logic [BW-1:0] i_strb_q, i_strb_d, q_strb_q, q_strb_d;
  logic          i_vld_q, i_vld_d, q_vld_q, q_vld_d;
  logic          i_last_q, i_last_d, q_last_q, q_last_d, hold_last_q, hold_last_d;
  logic          slot_free_i, slot_free_q, rdy, accept, in_last;

  assign slot_free_i = !i_vld_q || m_i_tready;
  assign slot_free_q = !q_vld_q || m_q_tready;
  assign accept      = s_iq_tvalid && s_iq_tready;

`ifdef PIRADIP_DEINTERLEAVE_TLAST_EN
  assign in_last   = s_iq_tlast;
  assign m_i_tlast = i_last_q;
  assign m_q_tlast = q_last_q;
`else
  assign in_last   = 1'b0;
`endif

  // Enables only steer the block while accepting; PH1 finishes the latched mode.
  always_comb begin
    mode_cur = (state_q == PH0) ? {i_en, q_en} : mode_q;
    rdy      = 1'b0;
    if (state_q == PH0) begin
      case (mode_cur)
        2'b11:   rdy = slot_free_i && slot_free_q;
        2'b10:   rdy = slot_free_i;
        2'b01:   rdy = slot_free_q;
        default: rdy = 1'b1;
      endcase
    end
    s_iq_tready = rdy && !areset;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    i_data_d    = i_data_q;
    q_data_d    = q_data_q;
    i_last_d    = i_last_q;
    q_last_d    = q_last_q;
    i_vld_d     = i_vld_q && !m_i_tready;
    q_vld_d     = q_vld_q && !m_q_tready;

    if (accept) mode_d = mode_cur;

    if (state_q == PH0) begin
      if (accept) begin
        case (mode_cur)
          2'b11: begin
            for (int k = 0; k < N_SAMPLES; k++) begin
              i_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_iq_tdata[(2*k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
              q_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_iq_tdata[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
            i_vld_d  = 1'b1;
            q_vld_d  = 1'b1;
            i_last_d = in_last;
            q_last_d = in_last;
          end
          2'b10: begin
            i_data_d    = s_iq_tdata[OW-1:0];
            i_vld_d     = 1'b1;
            i_last_d    = 1'b0;
            hold_d      = s_iq_tdata[IW-1:OW];
            hold_last_d = in_last;
            state_d     = PH1;
          end
          2'b01: begin
            q_data_d    = s_iq_tdata[OW-1:0];
            q_vld_d     = 1'b1;
            q_last_d    = 1'b0;
            hold_d      = s_iq_tdata[IW-1:OW];
            hold_last_d = in_last;
            state_d     = PH1;
          end
          default: ;
        endcase
      end
    end else begin
      case (mode_q)
        2'b10: if (slot_free_i) begin
          i_data_d = hold_q;
          i_vld_d  = 1'b1;
          i_last_d = hold_last_q;
          state_d  = PH0;
        end
        2'b01: if (slot_free_q) begin
          q_data_d = hold_q;
          q_vld_d  = 1'b1;
          q_last_d = hold_last_q;
          state_d  = PH0;
        end
        default: state_d = PH0;
      endcase
    end

    i_strb_d = {BW{i_vld_d}};
    q_strb_d = {BW{q_vld_d}};
  end

  // Output slots and FSM register stage
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= PH0;
      mode_q      <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      i_data_q    <= '0;
      q_data_q    <= '0;
      i_strb_q    <= '0;
      q_strb_q    <= '0;
      i_vld_q     <= 1'b0;
      q_vld_q     <= 1'b0;
      i_last_q    <= 1'b0;
      q_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      i_data_q    <= i_data_d;
      q_data_q    <= q_data_d;
      i_strb_q    <= i_strb_d;
      q_strb_q    <= q_strb_d;
      i_vld_q     <= i_vld_d;
      q_vld_q     <= q_vld_d;
      i_last_q    <= i_last_d;
      q_last_q    <= q_last_d;
    end
  end

  assign m_i_tdata  = i_data_q;
  assign m_i_tstrb  = i_strb_q;
  assign m_i_tvalid = i_vld_q;
  assign m_q_tdata  = q_data_q;
  assign m_q_tstrb  = q_strb_q;
  assign m_q_tvalid = q_vld_q;

endmodule
